multiplier: RTL and testbench

- Iterative, unsigned radix-2 shift-add multiplier: 16-bit a times 16-bit b gives a 32-bit product r.
- It has no start strobe. It captures the operands itself and recomputes whenever a or b changes.
- `validity` flags that r holds the product of the operands currently applied.
- Used as a multi-cycle arithmetic unit in the MIPS datapath, in place of a large combinational array.

---
 rtl/mul_pkg.sv | 13 +
 rtl/multiplier.sv | 124 ++++++++++++
 tb/tb_multiplier.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package mul_pkg;

  localparam int WIDTH = 16;
  localparam int ITER  = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multiplier.sv
// Unsigned radix-2 shift-add multiplier. Captures its own operands and
// recomputes whenever a or b changes; validity marks r as the product of the
// operands currently applied.
//
// state | meaning
// IDLE  | after reset: capture operands on the next edge, then BUSY
// BUSY  | one shift-add step per edge, ITER steps, last step writes r
// DONE  | r valid; hold until a or b differs from the captured copy
module multiplier #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   r,
  output logic                 validity
);
  import mul_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_reg_q, a_reg_d;
  logic [WIDTH-1:0]   b_reg_q, b_reg_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] r_q, r_d;
  logic               valid_q, valid_d;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;
  logic               operands_changed;

  assign addend           = mplier_q[0] ? mcand_q : '0;
  assign acc_sum          = acc_q + addend;
  assign operands_changed = (a != a_reg_q) || (b != b_reg_q);

  // Next-state and datapath: defaults hold everything, each state overrides.
  always_comb begin
    state_d  = state_q;
    a_reg_d  = a_reg_q;
    b_reg_d  = b_reg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    valid_d  = valid_q;

    case (state_q)
      IDLE: begin
        a_reg_d  = a;
        b_reg_d  = b;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        valid_d  = 1'b0;
        state_d  = BUSY;
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          r_d     = acc_sum;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // r keeps the old product until the new one is written.
        if (operands_changed) begin
          a_reg_d  = a;
          b_reg_d  = b;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          valid_d  = 1'b0;
          state_d  = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any partial work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_reg_q  <= a_reg_d;
      b_reg_q  <= b_reg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      valid_q  <= valid_d;
    end
  end

  assign r        = r_q;
  assign validity = valid_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the iterative multiplier: stimulus pushes expected
// products, a monitor pops one on every rising edge of validity.
module tb_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] r;
  logic        validity;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        vprev;

  multiplier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .r        (r),
    .validity (validity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every new valid product must match the oldest expectation.
  initial vprev = 1'b0;
  always @(negedge clk) begin
    if (validity === 1'b1 && vprev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got r=0x%08h with no expected product", r);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (r !== e) begin
          errors++;
          $display("FAIL product: got 0x%08h expected 0x%08h at %0t", r, e, $time);
        end
      end
    end
    vprev = validity;
  end

  // nlow sampled edges with validity low and r stale, then validity high.
  task automatic run_check(input int nlow, input logic [31:0] hold, input string name);
    int bad_v;
    int bad_r;
    bad_v = 0;
    bad_r = 0;
    for (int i = 0; i < nlow; i++) begin
      @(negedge clk);
      if (validity !== 1'b0) bad_v++;
      if (r !== hold) bad_r++;
    end
    check({name, "_busy_low_cycles"}, 32'(bad_v), 32'd0);
    check({name, "_stale_r_cycles"}, 32'(bad_r), 32'd0);
    @(negedge clk);
    check({name, "_valid_rise"}, {31'd0, validity}, 32'd1);
  endtask

  // Called at a negedge: apply new operands and check the full recompute.
  task automatic apply(input logic [15:0] na, input logic [15:0] nb,
                       input logic [31:0] expv, input logic [31:0] hold,
                       input string name);
    a = na;
    b = nb;
    exp_q.push_back(expv);
    run_check(16, hold, name);
  endtask

  logic [31:0] last_r;
  logic [15:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    a     = 16'd11;
    b     = 16'd4;
    repeat (2) @(negedge clk);
    check("reset_r", r, 32'd0);
    check("reset_validity", {31'd0, validity}, 32'd0);

    // 11*4 from reset: capture on first edge, valid on the 17th.
    exp_q.push_back(32'd44);
    rst_n = 1'b1;
    run_check(16, 32'd0, "first_11x4");
    repeat (3) @(negedge clk);
    check("hold_r", r, 32'd44);
    check("hold_validity", {31'd0, validity}, 32'd1);

    apply(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'd44, "max_x_max");
    apply(16'h0000, 16'h1234, 32'd0, 32'hFFFE0001, "zero_a");
    apply(16'd11, 16'd4, 32'd44, 32'd0, "again_11x4");
    apply(16'd3, 16'd4, 32'd12, 32'd44, "change_3x4");

    // Change a on the 5th busy edge: captured operands win, then a restart.
    a = 16'd11;
    b = 16'd4;
    exp_q.push_back(32'd44);
    repeat (5) @(negedge clk);
    a = 16'd7;
    exp_q.push_back(32'd28);
    run_check(11, 32'd12, "ignore_midbusy");
    check("midbusy_r", r, 32'd44);
    run_check(16, 32'd44, "restart_7x4");
    check("restart_r", r, 32'd28);

    // Reset on the 8th busy edge discards the partial product.
    a = 16'd11;
    b = 16'd4;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_r", r, 32'd0);
    check("midreset_validity", {31'd0, validity}, 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'd44);
    run_check(16, 32'd0, "after_reset_11x4");

    last_r = 32'd44;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 50 == 0) ra = 16'hFFFF;
      if (ra == a && rb == b) rb = rb + 16'd1;
      apply(ra, rb, 32'(ra) * 32'(rb), last_r, "random");
      last_r = 32'(ra) * 32'(rb);
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
